cpu_mem_arbiter: RTL and testbench

Arbiter and sequencer that shares the CPU's single memory master port between three requesters: instruction fetch (IF), data-memory read (DM-R) and data-memory write (DM-W). It sits between the CPU pipeline's fetch and MEM stages and the bus master interface. It serialises accesses through a four-state FSM and returns per-requester stall, data and valid signals. Arbitration is fixed priority with starvation protection for fetch.

---
 rtl/cpu_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// Shares the CPU's single memory master port between instruction fetch, data read and
// data write through a four-state sequencer; fixed priority with fetch starvation relief.
module cpu_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_stall,
    output logic [DATA_W-1:0]     o_if_rdata,
    output logic                  o_if_rvalid,
    input  logic                  i_dm_rreq,
    input  logic [ADDR_W-1:0]     i_dm_raddr,
    output logic                  o_dm_rstall,
    output logic [DATA_W-1:0]     o_dm_rdata,
    output logic                  o_dm_rvalid,
    input  logic                  i_dm_wreq,
    input  logic [ADDR_W-1:0]     i_dm_waddr,
    input  logic [DATA_W-1:0]     i_dm_wdata,
    input  logic [DATA_W/8-1:0]   i_dm_wstrb,
    output logic                  o_dm_wstall,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_write,
    output logic [ADDR_W-1:0]     o_mem_req_addr,
    output logic [DATA_W-1:0]     o_mem_req_wdata,
    output logic [DATA_W/8-1:0]   o_mem_req_wstrb,
    input  logic                  i_mem_resp_valid,
    input  logic [DATA_W-1:0]     i_mem_resp_rdata,
    output logic [1:0]            o_owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DMR  = 2'd2;
    localparam logic [1:0] OWN_DMW  = 2'd3;

    localparam logic [3:0] STARVE_MAX = STARVE_LIM[3:0];

    logic [1:0]          r_state;
    logic [1:0]          r_owner;
    logic [3:0]          r_starve_cnt;
    logic                r_req_valid;
    logic                r_req_write;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [DATA_W/8-1:0] r_req_wstrb;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_if_rvalid;
    logic                r_dm_rvalid;
    logic [1:0]          w_grant;

    // Fixed-priority winner; a starved fetch jumps ahead of both data requesters.
    always_comb begin
        w_grant = OWN_NONE;
        if (i_if_req && (r_starve_cnt == STARVE_MAX)) begin
            w_grant = OWN_IF;
        end else if (i_dm_wreq) begin
            w_grant = OWN_DMW;
        end else if (i_dm_rreq) begin
            w_grant = OWN_DMR;
        end else if (i_if_req) begin
            w_grant = OWN_IF;
        end else begin
            w_grant = OWN_NONE;
        end
    end

    // Sequencer state and current owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= OWN_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant != OWN_NONE) begin
                        r_state <= S_ISSUE;
                        r_owner <= w_grant;
                    end
                end
                S_ISSUE: begin
                    if (i_mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mem_resp_valid) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_owner <= OWN_NONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Request registers: latched once at grant so requester inputs may change afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
        end else if ((r_state == S_IDLE) && (w_grant != OWN_NONE)) begin
            r_req_valid <= 1'b1;
            case (w_grant)
                OWN_DMW: begin
                    r_req_write <= 1'b1;
                    r_req_addr  <= i_dm_waddr;
                    r_req_wdata <= i_dm_wdata;
                    r_req_wstrb <= i_dm_wstrb;
                end
                OWN_DMR: begin
                    r_req_write <= 1'b0;
                    r_req_addr  <= i_dm_raddr;
                    r_req_wdata <= '0;
                    r_req_wstrb <= '0;
                end
                default: begin
                    r_req_write <= 1'b0;
                    r_req_addr  <= i_if_addr;
                    r_req_wdata <= '0;
                    r_req_wstrb <= '0;
                end
            endcase
        end else if ((r_state == S_ISSUE) && i_mem_req_ready) begin
            r_req_valid <= 1'b0;
        end
    end

    // Count arbitrations fetch loses while waiting; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if ((r_state == S_IDLE) && (w_grant != OWN_NONE)) begin
            if (w_grant == OWN_IF) begin
                r_starve_cnt <= 4'd0;
            end else if (i_if_req && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    // Read data capture; valid pulses during DONE only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            if ((r_state == S_WAIT) && i_mem_resp_valid) begin
                case (r_owner)
                    OWN_IF: begin
                        r_if_rdata  <= i_mem_resp_rdata;
                        r_if_rvalid <= 1'b1;
                    end
                    OWN_DMR: begin
                        r_dm_rdata  <= i_mem_resp_rdata;
                        r_dm_rvalid <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_if_stall  = i_if_req  && !((r_state == S_DONE) && (r_owner == OWN_IF));
    assign o_dm_rstall = i_dm_rreq && !((r_state == S_DONE) && (r_owner == OWN_DMR));
    assign o_dm_wstall = i_dm_wreq && !((r_state == S_DONE) && (r_owner == OWN_DMW));

    assign o_if_rdata      = r_if_rdata;
    assign o_if_rvalid     = r_if_rvalid;
    assign o_dm_rdata      = r_dm_rdata;
    assign o_dm_rvalid     = r_dm_rvalid;
    assign o_mem_req_valid = r_req_valid;
    assign o_mem_req_write = r_req_write;
    assign o_mem_req_addr  = r_req_addr;
    assign o_mem_req_wdata = r_req_wdata;
    assign o_mem_req_wstrb = r_req_wstrb;
    assign o_owner         = r_owner;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: expected grants are queued as stimulus is
// applied and checked as the arbiter issues each bus request.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_rreq, dm_wreq;
    logic [31:0] if_addr, dm_raddr, dm_waddr, dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        if_stall, dm_rstall, dm_wstall, if_rvalid, dm_rvalid;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic [3:0]  mem_req_wstrb;
    logic [1:0]  owner;

    typedef struct {
        logic [1:0]  owner;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_done = 0;
    int   t_req;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_stall(if_stall),
        .o_if_rdata(if_rdata), .o_if_rvalid(if_rvalid),
        .i_dm_rreq(dm_rreq), .i_dm_raddr(dm_raddr), .o_dm_rstall(dm_rstall),
        .o_dm_rdata(dm_rdata), .o_dm_rvalid(dm_rvalid),
        .i_dm_wreq(dm_wreq), .i_dm_waddr(dm_waddr), .i_dm_wdata(dm_wdata),
        .i_dm_wstrb(dm_wstrb), .o_dm_wstall(dm_wstall),
        .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready),
        .o_mem_req_write(mem_req_write), .o_mem_req_addr(mem_req_addr),
        .o_mem_req_wdata(mem_req_wdata), .o_mem_req_wstrb(mem_req_wstrb),
        .i_mem_resp_valid(mem_resp_valid), .i_mem_resp_rdata(mem_resp_rdata),
        .o_owner(owner)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] o, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd);
        exp_t e;
        e.owner = o; e.write = w; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic drop_req(input logic [1:0] o);
        case (o)
            2'd1: if_req = 1'b0;
            2'd2: dm_rreq = 1'b0;
            2'd3: dm_wreq = 1'b0;
            default: ;
        endcase
    endtask

    task automatic wait_issue(output exp_t e);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("issue_seen", {31'd0, mem_req_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, {31'd0, mem_req_valid});
            e = '{2'd0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0};
        end else begin
            e = exp_q.pop_front();
        end
        check_eq("owner", {30'd0, owner}, {30'd0, e.owner});
        check_eq("req_write", {31'd0, mem_req_write}, {31'd0, e.write});
        check_eq("req_addr", mem_req_addr, e.addr);
        check_eq("req_wdata", mem_req_wdata, e.wdata);
        check_eq("req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, e.wstrb});
    endtask

    // drop: 0 keep requests, 1 drop owner in DONE, 2 drop owner in WAIT, 3 drop all in DONE
    task automatic serve(input int rdly, input int sdly, input int drop, input bit scramble);
        exp_t e;
        int   t0;
        wait_issue(e);
        t0 = cyc;
        repeat (rdly) begin
            if (scramble) begin
                dm_waddr = $urandom;
                dm_wdata = $urandom;
            end
            step();
            check_eq("hold_valid", {31'd0, mem_req_valid}, 32'd1);
            check_eq("hold_addr", mem_req_addr, e.addr);
            check_eq("hold_wdata", mem_req_wdata, e.wdata);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check_eq("valid_drop", {31'd0, mem_req_valid}, 32'd0);
        if (drop == 2) drop_req(e.owner);
        repeat (sdly) step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = e.rdata;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'hFFFF_FFFF;
        last_done = cyc;
        check_eq("latency", t0 + 2 + rdly + sdly, cyc);
        check_eq("done_owner", {30'd0, owner}, {30'd0, e.owner});
        case (e.owner)
            2'd1: begin
                check_eq("if_rvalid", {31'd0, if_rvalid}, 32'd1);
                check_eq("if_rdata", if_rdata, e.rdata);
                check_eq("if_stall_done", {31'd0, if_stall}, 32'd0);
                check_eq("dm_rvalid_quiet", {31'd0, dm_rvalid}, 32'd0);
            end
            2'd2: begin
                check_eq("dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
                check_eq("dm_rdata", dm_rdata, e.rdata);
                check_eq("dm_rstall_done", {31'd0, dm_rstall}, 32'd0);
                check_eq("if_rvalid_quiet", {31'd0, if_rvalid}, 32'd0);
            end
            default: begin
                check_eq("write_no_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
                check_eq("dm_wstall_done", {31'd0, dm_wstall}, 32'd0);
            end
        endcase
        if (drop == 1) drop_req(e.owner);
        if (drop == 3) begin
            if_req = 1'b0; dm_rreq = 1'b0; dm_wreq = 1'b0;
        end
        step();
        check_eq("rvalid_pulse", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        check_eq("owner_idle", {30'd0, owner}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_1000;
        dm_rreq = 1'b0; dm_raddr = 32'd0;
        dm_wreq = 1'b0; dm_waddr = 32'd0; dm_wdata = 32'd0; dm_wstrb = 4'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
        step();
        step();

        // reset state while fetch is requesting
        check_eq("rst_valid", {31'd0, mem_req_valid}, 32'd0);
        check_eq("rst_owner", {30'd0, owner}, 32'd0);
        check_eq("rst_if_stall", {31'd0, if_stall}, 32'd1);
        check_eq("rst_req_fields", {mem_req_write, mem_req_wstrb, 27'd0}, 32'd0);
        check_eq("rst_req_addr", mem_req_addr, 32'd0);
        check_eq("rst_rdata", if_rdata | dm_rdata, 32'd0);

        // minimum-latency fetch
        push_exp(2'd1, 1'b0, 32'h0000_1000, 32'd0, 4'd0, 32'h0000_0013);
        rst = 1'b0;
        t_req = cyc;
        serve(0, 0, 1, 1'b0);
        check_eq("min_latency", last_done - t_req, 32'd3);

        // three simultaneous requests: write, read, fetch in that order
        dm_wreq = 1'b1; dm_waddr = 32'h0000_2004; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011;
        dm_rreq = 1'b1; dm_raddr = 32'h0000_3008;
        if_req = 1'b1; if_addr = 32'h0000_1004;
        push_exp(2'd3, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 32'd0);
        push_exp(2'd2, 1'b0, 32'h0000_3008, 32'd0, 4'd0, 32'h3008_A5A5);
        push_exp(2'd1, 1'b0, 32'h0000_1004, 32'd0, 4'd0, 32'h1004_5A5A);
        for (int i = 0; i < 3; i++) serve(0, i, 1, 1'b0);

        // starvation: fetch wins after four losses, counter restarts afterwards
        dm_wreq = 1'b1; dm_waddr = 32'h0000_7000; dm_wdata = 32'h0BAD_F00D; dm_wstrb = 4'b1111;
        dm_rreq = 1'b1; dm_raddr = 32'h0000_7100;
        if_req = 1'b1; if_addr = 32'h0000_1010;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++)
                push_exp(2'd3, 1'b1, 32'h0000_7000, 32'h0BAD_F00D, 4'b1111, 32'd0);
            push_exp(2'd1, 1'b0, 32'h0000_1010, 32'd0, 4'd0, 32'h1010_0000 + 32'(k));
        end
        for (int i = 0; i < 10; i++) serve(i % 2, 0, (i == 9) ? 3 : 0, 1'b0);

        // ready stalled five cycles while write inputs change
        dm_wreq = 1'b1; dm_waddr = 32'h0000_4000; dm_wdata = 32'h1111_2222; dm_wstrb = 4'b1111;
        push_exp(2'd3, 1'b1, 32'h0000_4000, 32'h1111_2222, 4'b1111, 32'd0);
        t_req = cyc;
        serve(5, 0, 1, 1'b1);
        check_eq("ready_wait_latency", last_done - t_req, 32'd8);

        // reset during WAIT abandons the transaction
        dm_rreq = 1'b1; dm_raddr = 32'h0000_5000;
        push_exp(2'd2, 1'b0, 32'h0000_5000, 32'd0, 4'd0, 32'd0);
        wait_issue(e);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        dm_rreq = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", {31'd0, mem_req_valid}, 32'd0);
        check_eq("async_rst_owner", {30'd0, owner}, 32'd0);
        step();
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("idle_resp_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
            check_eq("idle_resp_rdata", dm_rdata, 32'd0);
            check_eq("idle_resp_owner", {29'd0, mem_req_valid, owner}, 32'd0);
        end
        mem_resp_valid = 1'b0;

        // read withdrawn during WAIT still completes, then fetch is granted
        dm_rreq = 1'b1; dm_raddr = 32'h0000_6000;
        if_req = 1'b1; if_addr = 32'h0000_1020;
        push_exp(2'd2, 1'b0, 32'h0000_6000, 32'd0, 4'd0, 32'h600D_600D);
        push_exp(2'd1, 1'b0, 32'h0000_1020, 32'd0, 4'd0, 32'h0000_0093);
        serve(0, 2, 2, 1'b0);
        serve(0, 0, 1, 1'b0);
        check_eq("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
